// File: rtl/div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_pkg : shared widths, iteration count and FSM encoding for div_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int ITER_COUNT = DIV_WIDTH;
  localparam int CNT_W      = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_step : one restoring shift-subtract step on unsigned magnitudes
// Revision: 1.0
// ---------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_neg;

  // rem_i < dvsr_i, so the shifted value never overflows WIDTH bits and
  // bit WIDTH of the difference is a clean borrow flag.
  assign w_shifted = {rem_i, quo_i[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, dvsr_i};
  assign w_neg     = w_diff[WIDTH];

  assign rem_o = w_neg ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~w_neg};

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_unit : multi-cycle signed restoring divider, result = {remainder, quotient}
// Revision: 1.0
// ---------------------------------------------------------------------------
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int N_ITER = (WIDTH == DIV_WIDTH) ? ITER_COUNT : WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
  logic               qneg_q, rneg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, dbz_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   rem_d, quo_d;
  logic [WIDTH-1:0]   w_rem_fix, w_quo_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_d),
    .quo_o  (quo_d)
  );

  assign w_rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
  assign w_quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= dividend;
            b_q     <= divisor;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          qneg_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          rneg_q <= a_q[WIDTH-1];
          rem_q  <= '0;
          quo_q  <= a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
          dvsr_q <= b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
          cnt_q  <= '0;
          if (b_q == '0) begin
            // Divide-by-zero bypasses iteration: all-ones quotient, raw dividend as remainder.
            result_q <= {a_q, {WIDTH{1'b1}}};
            dbz_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            dbz_q   <= 1'b0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          result_q <= {w_rem_fix, w_quo_fix};
          done_q   <= 1'b1;
          cnt_q    <= '0;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign result      = result_q;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_unit : directed and random checks of div_unit against an arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic          Clock = 1'b0;
  logic          Clear = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor  = '0;
  logic          busy, done, div_by_zero;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(W)) dut (
    .Clock       (Clock),
    .Clear       (Clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division done in 64-bit so -2^31/-1 cannot trap.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit repulse);
    int          lat;
    logic [63:0] exp;
    exp = model(a, b);
    lat = 0;
    @(negedge Clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge Clock);
    #1;
    check({tag, ":busy"}, 64'(busy), 64'd1);
    @(negedge Clock);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clock);
      #1;
      if (done) begin
        lat = n + 1;
        break;
      end
      if (repulse && n == 10) begin
        start    = 1'b1;
        dividend = 32'd99;
        divisor  = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, ":latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd35);
    check({tag, ":result"}, result, exp);
    check({tag, ":dbz"}, 64'(div_by_zero), (b == 32'd0) ? 64'd1 : 64'd0);
    if (repulse) start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    check({tag, ":done_drop"}, 64'(done), 64'd0);
    check({tag, ":idle"}, 64'(busy), 64'd0);
    @(posedge Clock);
    #1;
    check({tag, ":hold"}, result, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;

    #12;
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:done", 64'(done), 64'd0);
    check("reset:dbz", 64'(div_by_zero), 64'd0);
    check("reset:result", result, 64'd0);
    @(negedge Clock);
    Clear = 1'b1;

    run_div(32'd12, 32'd15, "12/15", 1'b0);
    check("12/15:const", result, 64'h0000000C_00000000);
    run_div(-32'sd7, 32'd2, "-7/2", 1'b0);
    check("-7/2:const", result, 64'hFFFFFFFF_FFFFFFFD);
    run_div(32'd10, 32'd0, "10/0", 1'b0);
    check("10/0:const", result, 64'h0000000A_FFFFFFFF);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "ovf", 1'b0);
    check("ovf:const", result, 64'h00000000_80000000);
    run_div(32'd15, 32'd4, "15/4_repulse", 1'b1);
    check("15/4:const", result, 64'h00000003_00000003);

    // Asynchronous clear in the middle of iteration.
    @(negedge Clock);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    repeat (11) @(posedge Clock);
    #3;
    Clear = 1'b0;
    #1;
    check("clr:busy", 64'(busy), 64'd0);
    check("clr:done", 64'(done), 64'd0);
    check("clr:dbz", 64'(div_by_zero), 64'd0);
    check("clr:result", result, 64'd0);
    @(negedge Clock);
    Clear = 1'b1;
    run_div(32'd100, 32'd7, "100/7", 1'b0);
    check("100/7:const", result, 64'h00000002_0000000E);

    run_div(-32'sd100, 32'd7, "-100/7", 1'b0);
    run_div(32'd100, -32'sd7, "100/-7", 1'b0);
    run_div(32'd0, 32'd5, "0/5", 1'b0);
    run_div(32'h7FFF_FFFF, 32'h8000_0000, "max/min", 1'b0);
    run_div(32'h8000_0000, 32'd1, "min/1", 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(0, 30);
      run_div(ra, rb, $sformatf("rnd%0d", i), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_unit
`default_nettype wire
